// File: rtl/pll_reset_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// Optional lock-loss counting is enabled by the PLL_RESET_LOSS_COUNT_EN macro.
package pll_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        STABLE     = 2'd1,
        PERIPH_REL = 2'd2,
        RUN        = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_RESET_GAP_CYCLES   = 16;
    localparam int LOSS_COUNT_W           = 8;

    // Width that holds the larger of the two terminal counts without wrapping.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit, async active-high reset to 0.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock qualification and staged peripheral/core reset release.
// Define PLL_RESET_LOSS_COUNT_EN to add the saturating lock_loss_count output.
//
// state      | meaning
// WAIT_LOCK  | both resets held, waiting for synchronized lock
// STABLE     | counting consecutive lock cycles, both resets held
// PERIPH_REL | periph_reset released, counting gap before core release
// RUN        | both resets released, ready asserted
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int RESET_GAP_CYCLES   = DEF_RESET_GAP_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       soft_reset_req,
    output logic       periph_reset,
    output logic       core_reset,
    output logic       ready
`ifdef PLL_RESET_LOSS_COUNT_EN
    ,
    output logic [7:0] lock_loss_count
`endif
);

    localparam int CW = cnt_width(LOCK_STABLE_CYCLES, RESET_GAP_CYCLES);

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] STABLE_END = CW'(LOCK_STABLE_CYCLES);
    localparam logic [CW-1:0] GAP_END    = CW'(RESET_GAP_CYCLES - 1);

    logic          lock_s;
    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          periph_next, core_next, ready_next;
`ifdef PLL_RESET_LOSS_COUNT_EN
    logic          loss_evt;
`endif

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clock(clock),
        .reset(reset),
        .d    (pll_lock),
        .q    (lock_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            periph_reset <= 1'b1;
            core_reset   <= 1'b1;
            ready        <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            periph_reset <= periph_next;
            core_reset   <= core_next;
            ready        <= ready_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
`ifdef PLL_RESET_LOSS_COUNT_EN
        loss_evt   = 1'b0;
`endif
        case (state)
            WAIT_LOCK: begin
                if (soft_reset_req) begin
                    cnt_next = '0;
                end else if (lock_s) begin
                    state_next = STABLE;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            STABLE: begin
                if (soft_reset_req || !lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == STABLE_END) begin
                    state_next = PERIPH_REL;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            PERIPH_REL: begin
                // Lock loss wins over a simultaneous soft request so it is counted.
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
`ifdef PLL_RESET_LOSS_COUNT_EN
                    loss_evt   = 1'b1;
`endif
                end else if (soft_reset_req) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == GAP_END) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            RUN: begin
                cnt_next = '0;
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
`ifdef PLL_RESET_LOSS_COUNT_EN
                    loss_evt   = 1'b1;
`endif
                end else if (soft_reset_req) begin
                    state_next = WAIT_LOCK;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they change on the transition edge.
    always_comb begin
        periph_next = (state_next == WAIT_LOCK) || (state_next == STABLE);
        core_next   = (state_next != RUN);
        ready_next  = (state_next == RUN);
    end

`ifdef PLL_RESET_LOSS_COUNT_EN
    logic [LOSS_COUNT_W-1:0] loss_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            loss_cnt <= '0;
        end else if (loss_evt && (loss_cnt != {LOSS_COUNT_W{1'b1}})) begin
            loss_cnt <= loss_cnt + LOSS_COUNT_W'(1);
        end
    end

    assign lock_loss_count = loss_cnt;
`endif

endmodule
